// File: rtl/ppu_bg_fetch.sv
// Background tile fetch pipeline: an 8-phase NT/AT/pattern-lo/pattern-hi read sequence feeding 16-bit shifters, one pixel per clock.
// Optional left-edge clipping is enabled with PPU_BG_CLIP_EN, which adds the clip_left and x_pos inputs.
//
// phase        | meaning
// PH_NT        | nametable address presented
// PH_NT_CAP    | nametable byte returns, captured at end of phase
// PH_AT        | attribute address presented
// PH_AT_CAP    | attribute byte returns, quadrant bits captured
// PH_PT_LO     | pattern-lo address presented
// PH_PT_LO_CAP | pattern-lo byte returns, captured
// PH_PT_HI     | pattern-hi address presented
// PH_LOAD      | pattern-hi byte returns; shifters load at end, inc_hori high
module ppu_bg_fetch #(
  parameter logic [13:0] NT_BASE   = 14'h2000,
  parameter logic [9:0]  AT_OFFSET = 10'h3C0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        shift_en,
  input  logic [14:0] v,
  input  logic        bg_pt_sel,
  input  logic [2:0]  fine_x,
  input  logic [7:0]  mem_data,
`ifdef PPU_BG_CLIP_EN
  input  logic        clip_left,
  input  logic [7:0]  x_pos,
`endif
  output logic [13:0] mem_addr,
  output logic        mem_rw,
  output logic [3:0]  pixel,
  output logic        inc_hori
);

  typedef enum logic [2:0] {
    PH_NT        = 3'd0,
    PH_NT_CAP    = 3'd1,
    PH_AT        = 3'd2,
    PH_AT_CAP    = 3'd3,
    PH_PT_LO     = 3'd4,
    PH_PT_LO_CAP = 3'd5,
    PH_PT_HI     = 3'd6,
    PH_LOAD      = 3'd7
  } phase_t;

  phase_t      phase_q, phase_d;
  logic [13:0] mem_addr_q, mem_addr_d;
  logic        run_q, run_d;
  logic        inc_hori_q, inc_hori_d;
  logic [7:0]  nt_byte_q, nt_byte_d;
  logic [1:0]  at_bits_q, at_bits_d;
  logic [7:0]  pt_lo_q, pt_lo_d;
  logic [15:0] pat_lo_q, pat_lo_d, pat_hi_q, pat_hi_d;
  logic [15:0] att_lo_q, att_lo_d, att_hi_q, att_hi_d;

  logic [13:0] nt_addr, at_addr, pt_addr;
  logic [1:0]  at_sel;
  logic        load;
  logic [15:0] pat_lo_sh, pat_hi_sh, att_lo_sh, att_hi_sh;
  logic [3:0]  idx;
  logic [3:0]  pix_raw;

  assign nt_addr = NT_BASE | {2'b00, v[11:0]};
  assign at_addr = NT_BASE | {2'b00, v[11:10], AT_OFFSET[9:6], v[9:7], v[4:2]};
  assign pt_addr = {1'b0, bg_pt_sel, nt_byte_q, 1'b0, v[14:12]};

  // Attribute quadrant select: {v[6], v[1]} picks the 2-bit field of the byte.
  always_comb begin
    case ({v[6], v[1]})
      2'b00:   at_sel = mem_data[1:0];
      2'b01:   at_sel = mem_data[3:2];
      2'b10:   at_sel = mem_data[5:4];
      default: at_sel = mem_data[7:6];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= PH_NT;
      mem_addr_q <= 14'h0000;
      run_q      <= 1'b0;
      inc_hori_q <= 1'b0;
      nt_byte_q  <= 8'h00;
      at_bits_q  <= 2'b00;
      pt_lo_q    <= 8'h00;
      pat_lo_q   <= 16'h0000;
      pat_hi_q   <= 16'h0000;
      att_lo_q   <= 16'h0000;
      att_hi_q   <= 16'h0000;
    end else begin
      phase_q    <= phase_d;
      mem_addr_q <= mem_addr_d;
      run_q      <= run_d;
      inc_hori_q <= inc_hori_d;
      nt_byte_q  <= nt_byte_d;
      at_bits_q  <= at_bits_d;
      pt_lo_q    <= pt_lo_d;
      pat_lo_q   <= pat_lo_d;
      pat_hi_q   <= pat_hi_d;
      att_lo_q   <= att_lo_d;
      att_hi_q   <= att_hi_d;
    end
  end

  always_comb begin
    phase_d    = phase_q;
    mem_addr_d = mem_addr_q;
    run_d      = fetch_en;
    inc_hori_d = 1'b0;
    nt_byte_d  = nt_byte_q;
    at_bits_d  = at_bits_q;
    pt_lo_d    = pt_lo_q;
    load       = 1'b0;
    if (!fetch_en) begin
      phase_d = PH_NT;
    end else begin
      phase_d = phase_t'(phase_q + 3'd1);
      case (phase_q)
        PH_NT_CAP:    nt_byte_d = mem_data;
        PH_AT_CAP:    at_bits_d = at_sel;
        PH_PT_LO_CAP: pt_lo_d   = mem_data;
        PH_LOAD:      load      = 1'b1;
        default: ;
      endcase
      case (phase_d)
        PH_NT:    mem_addr_d = nt_addr;
        PH_AT:    mem_addr_d = at_addr;
        PH_PT_LO: mem_addr_d = pt_addr;
        PH_PT_HI: mem_addr_d = pt_addr | 14'h0008;
        PH_LOAD:  inc_hori_d = 1'b1;
        default: ;
      endcase
      // A sequence starting from idle never saw the edge into PH_NT, so put the NT address out now.
      if (phase_q == PH_NT && !run_q) mem_addr_d = nt_addr;
    end
  end

  always_comb begin
    pat_lo_sh = shift_en ? {pat_lo_q[14:0], 1'b0} : pat_lo_q;
    pat_hi_sh = shift_en ? {pat_hi_q[14:0], 1'b0} : pat_hi_q;
    att_lo_sh = shift_en ? {att_lo_q[14:0], 1'b0} : att_lo_q;
    att_hi_sh = shift_en ? {att_hi_q[14:0], 1'b0} : att_hi_q;
    pat_lo_d  = load ? {pat_lo_sh[15:8], pt_lo_q}          : pat_lo_sh;
    pat_hi_d  = load ? {pat_hi_sh[15:8], mem_data}         : pat_hi_sh;
    att_lo_d  = load ? {att_lo_sh[15:8], {8{at_bits_q[0]}}} : att_lo_sh;
    att_hi_d  = load ? {att_hi_sh[15:8], {8{at_bits_q[1]}}} : att_hi_sh;
  end

  // Index 15 - fine_x.
  assign idx     = {1'b1, ~fine_x};
  assign pix_raw = {att_hi_q[idx], att_lo_q[idx], pat_hi_q[idx], pat_lo_q[idx]};

`ifdef PPU_BG_CLIP_EN
  assign pixel = (clip_left && (x_pos < 8'd8)) ? 4'h0 : pix_raw;
`else
  assign pixel = pix_raw;
`endif

  assign mem_addr = mem_addr_q;
  assign mem_rw   = 1'b1;
  assign inc_hori = inc_hori_q;

endmodule

// File: doc/ppu_bg_fetch.md
Name: ppu_bg_fetch

Overview:
- Background tile fetch pipeline of the PPU.
- Drives the PPU memory-map port (14-bit address, rw, registered read data) with the 8-cycle nametable / attribute / pattern-lo / pattern-hi fetch sequence.
- Loads the fetched bytes into 16-bit background shifters.
- Produces one 4-bit background pixel per clock, plus a coarse-X increment pulse for the scroll/loopy-register logic.

Parameters:
- NT_BASE, 14'h2000, nametable region base address.
- AT_OFFSET, 10'h3C0, attribute table offset within each 1 KB nametable.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- fetch_en  in  1  fetch window active (dots 1-256, 321-336)
- shift_en  in  1  advance background shifters this cycle
- v  in  15  current VRAM address: fine_y[14:12], nt[11:10], coarse_y[9:5], coarse_x[4:0]
- bg_pt_sel  in  1  background pattern table select (PPUCTRL bit 4)
- fine_x  in  3  fine X scroll
- mem_data  in  8  read data from memory map, valid one clock after address
- mem_addr  out  14  memory address
- mem_rw  out  1  constant 1 (read only)
- pixel  out  4  {palette[1:0], pattern[1:0]}
- inc_hori  out  1  one-cycle pulse: request coarse-X increment of v

Behaviour:
- Reset values: all registers zero; mem_addr=0, inc_hori=0, pixel=0, phase=0. Reset is asynchronous and may assert mid-sequence; the next fetch begins at phase 0.
- phase is a 3-bit counter.
  - fetch_en=1: increments every clock, wrapping 7 to 0.
  - fetch_en=0: phase is synchronously cleared to 0, mem_addr holds, and no captures or loads occur.
- mem_addr is registered. The address for phase p is registered at the clock edge that enters phase p, so mem_data is valid during phase p+1. Per phase:
  - 0: mem_addr = NT_BASE | v[11:0].
  - 1: capture nt_byte <= mem_data.
  - 2: mem_addr = NT_BASE | {v[11:10], AT_OFFSET[9:6], v[9:7], v[4:2]}.
  - 3: capture at_bits <= mem_data >> {v[6], v[1], 1'b0}, low 2 bits.
  - 4: mem_addr = {1'b0, bg_pt_sel, nt_byte, 1'b0, v[14:12]}.
  - 5: capture pt_lo <= mem_data.
  - 6: mem_addr = pattern-lo address | 14'h0008.
  - 7: load edge. pt_hi taken directly from mem_data. inc_hori=1 for exactly this cycle.
- Shifters: pat_lo, pat_hi, att_lo, att_hi, each 16 bits.
  - shift_en=1: each shifts left by 1.
  - Load edge (phase 7, fetch_en=1): shifter <= {shifted[15:8], new_byte}. The new low byte overrides the shifted low byte. new_byte is pt_lo, mem_data, {8{at_bits[0]}} and {8{at_bits[1]}} respectively.
  - Load and shift in the same cycle: the upper byte takes the shifted value.
- pixel is combinational from the shifter bits at index 15-fine_x: {att_hi, att_lo, pat_hi, pat_lo}.
- Latency: a tile loaded at load edge N shows its leftmost pixel (fine_x=0) in the cycle after load edge N+1, given continuous shift_en.

Optional Feature:
- Macro: PPU_BG_CLIP_EN.
- Defined:
  - Adds input ports clip_left (1 bit) and x_pos (8 bits).
  - pixel is forced to 4'h0 when clip_left=1 and x_pos<8.
  - Otherwise behaviour is unchanged.
- Undefined: the ports are absent and no clipping is applied.

Test Plan:
- Address sequence: v=15'h0147, bg_pt_sel=1, memory 0x2147=0x24, 0x23D1=0xE4 -> mem_addr sequence 0x2147, 0x23D1, 0x1240, 0x1248; captured at_bits=2'b11 (shift 6); inc_hori pulses once, at phase 7.
- Pixel output: two back-to-back tiles with pattern lo=0x80, hi=0x80, palette 3, fine_x=0, shift_en=1 -> pixel=4'hF in the cycle after the second load edge, then 4'hC for the next 7 cycles.
- Fine X: same stimulus with fine_x=3 -> the 4'hF pixel appears 3 cycles earlier than with fine_x=0.
- fetch_en gap: drop fetch_en at phase 4, hold 5 cycles, reassert -> phase restarts at 0; no inc_hori during the gap; shifters unchanged while shift_en=0.
- Reset mid-fetch: assert rst asynchronously at phase 5 -> pixel, mem_addr and inc_hori go to 0 immediately; after release the first mem_addr is an NT address.
- Clipping (PPU_BG_CLIP_EN defined): clip_left=1, x_pos=5 with opaque shifters -> pixel=0; x_pos=8 -> nonzero pixel.
